ballot_session_ctrl: RTL

Session controller for the four-candidate voting machine. It sits between the four debounced button controllers and the vote logger/mode logic. It opens and closes the poll, arms exactly one ballot per officer authorization, arbitrates simultaneous presses, and forwards a single one-hot grant to the logger. It also times out idle ballots, counts ballots cast, and gates result display until the poll is closed.

---
 rtl/ballot_pkg.sv | 15 +
 rtl/ballot_timer.sv | 35 +++
 rtl/ballot_session_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ballot_pkg.sv
// Shared types and constants for the ballot session controller.
// Holds the session state encoding and candidate sizing.
package ballot_pkg;

    localparam int NUM_CAND   = 4;
    localparam int CAND_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        OPEN_WAIT,
        ARMED,
        FINAL
    } state_t;

endpackage

// File: rtl/ballot_timer.sv
// Ballot expiry down-counter.
// Ports: clock, reset (sync, active-high); load reloads the counter,
// en counts while a ballot is armed, expire flags the last armed cycle.
module ballot_timer
    import ballot_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // Loaded with TIMEOUT_CYCLES-1 on arming, so zero marks the
    // final cycle of the armed window.
    assign expire = en && (count == '0);

endmodule

// File: rtl/ballot_session_ctrl.sv
// Poll/ballot session controller for the four-candidate voting machine.
// Ports: clock, reset (sync, active-high), open_poll, close_poll,
// authorize, vote_valid[3:0] in; vote_grant, ballot_ready, poll_open,
// results_en, timeout_evt, reject_evt, ballots_cast out (all registered).
module ballot_session_ctrl
    import ballot_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 8,
    parameter int MAX_BALLOTS    = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                open_poll,
    input  logic                close_poll,
    input  logic                authorize,
    input  logic [NUM_CAND-1:0] vote_valid,
    output logic [NUM_CAND-1:0] vote_grant,
    output logic                ballot_ready,
    output logic                poll_open,
    output logic                results_en,
    output logic                timeout_evt,
    output logic                reject_evt,
    output logic [CNT_W-1:0]    ballots_cast
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BALLOTS);

    state_t state;
    state_t state_n;

    logic                  close_pending;
    logic                  close_pending_n;
    logic                  closing;
    logic [CNT_W-1:0]      cnt_n;
    logic [NUM_CAND-1:0]   grant_n;
    logic                  timeout_n;
    logic                  reject_n;
    logic                  timer_load;
    logic                  timer_en;
    logic                  timer_expire;
    logic                  pick_found;
    logic [CAND_IDX_W-1:0] pick_idx;

    assign timer_en = (state == ARMED);

    ballot_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (timer_load),
        .en    (timer_en),
        .expire(timer_expire)
    );

    always_comb begin
        state_n         = state;
        close_pending_n = close_pending;
        cnt_n           = ballots_cast;
        grant_n         = '0;
        timeout_n       = 1'b0;
        timer_load      = 1'b0;
        closing         = close_pending | close_poll;
        pick_found      = 1'b0;
        pick_idx        = '0;

        // Descending scan so the lowest set index is the one kept.
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (vote_valid[i]) begin
                pick_found = 1'b1;
                pick_idx   = CAND_IDX_W'(i);
            end
        end

        reject_n = (state != ARMED) && (|vote_valid);

        unique case (state)
            IDLE: begin
                if (open_poll) begin
                    state_n = OPEN_WAIT;
                end
            end
            OPEN_WAIT: begin
                if (close_poll) begin
                    state_n = FINAL;
                end else if (authorize) begin
                    state_n    = ARMED;
                    timer_load = 1'b1;
                end
            end
            ARMED: begin
                if (pick_found) begin
                    grant_n[pick_idx] = 1'b1;
                    if (ballots_cast != MAX_C) begin
                        cnt_n = ballots_cast + CNT_W'(1);
                    end
                    state_n = (closing || (cnt_n == MAX_C)) ? FINAL : OPEN_WAIT;
                    close_pending_n = 1'b0;
                end else if (timer_expire) begin
                    timeout_n       = 1'b1;
                    state_n         = closing ? FINAL : OPEN_WAIT;
                    close_pending_n = 1'b0;
                end else if (close_poll) begin
                    close_pending_n = 1'b1;
                end
            end
            FINAL: begin
                state_n = FINAL;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            close_pending <= 1'b0;
            ballots_cast  <= '0;
            vote_grant    <= '0;
            ballot_ready  <= 1'b0;
            poll_open     <= 1'b0;
            results_en    <= 1'b0;
            timeout_evt   <= 1'b0;
            reject_evt    <= 1'b0;
        end else begin
            state         <= state_n;
            close_pending <= close_pending_n;
            ballots_cast  <= cnt_n;
            vote_grant    <= grant_n;
            ballot_ready  <= (state_n == ARMED);
            poll_open     <= (state_n == OPEN_WAIT) || (state_n == ARMED);
            results_en    <= (state_n == FINAL);
            timeout_evt   <= timeout_n;
            reject_evt    <= reject_n;
        end
    end

endmodule
